// File: rtl/link_motion_if.sv
// Sprite-motion bundle between link_motion_ctrl (master) and the sprite renderer (slave):
// raster position, keycode and collision in; sprite position and animation state out.
interface link_motion_if;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic [7:0] keycode;
    logic       collision;
    logic [9:0] spriteX;
    logic [9:0] spriteY;
    logic [9:0] sprite_size;
    logic [1:0] facing;
    logic       anim_frame;
    logic       frame_update;
    logic       blocked;

    modport master (
        input  DrawX, DrawY, keycode, collision,
        output spriteX, spriteY, sprite_size, facing, anim_frame, frame_update, blocked
    );

    modport slave (
        output DrawX, DrawY, keycode, collision,
        input  spriteX, spriteY, sprite_size, facing, anim_frame, frame_update, blocked
    );
endinterface

// File: rtl/link_motion_ctrl.sv
// Player sprite position/facing/walk animation, updated once per video frame with collision
// rollback and a post-collision lockout. Define SCREEN_WRAP_EN to wrap at screen edges instead of clamping.
module link_motion_ctrl #(
    parameter int INIT_X       = 304,
    parameter int INIT_Y       = 224,
    parameter int STEP         = 2,
    parameter int SPRITE_SIZE  = 32,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int ANIM_DIV     = 8,
    parameter int BLOCK_FRAMES = 4
) (
    input  logic          vga_clk,
    input  logic          Reset,
    link_motion_if.master lm
);
    localparam logic [7:0] KEY_UP    = 8'h1A;
    localparam logic [7:0] KEY_DOWN  = 8'h16;
    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int ANIM_W = $clog2(ANIM_DIV + 1);
    localparam int BLK_W  = $clog2(BLOCK_FRAMES + 1);

    localparam logic signed [10:0] STEP_S = 11'(STEP);
    localparam logic signed [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE_SIZE);
    localparam logic signed [10:0] Y_MAX  = 11'(V_ACTIVE - SPRITE_SIZE);

    localparam logic [9:0]        TICK_LINE = 10'(V_ACTIVE);
    localparam logic [9:0]        INIT_X_V  = 10'(INIT_X);
    localparam logic [9:0]        INIT_Y_V  = 10'(INIT_Y);
    localparam logic [9:0]        SIZE_V    = 10'(SPRITE_SIZE);
    localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(ANIM_DIV - 1);
    localparam logic [BLK_W-1:0]  BLK_LOAD  = BLK_W'(BLOCK_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_BLOCKED} state_t;

    state_t            state;
    logic              tick_cmp_p0;
    logic              tick_cmp_p1;
    logic              tick_vld;
    logic              hit_q;
    logic              hit;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic [9:0]        safe_x;
    logic [9:0]        safe_y;
    logic [1:0]        facing_q;
    logic              anim_q;
    logic              fu_q;
    logic              blk_q;
    logic [ANIM_W-1:0] anim_cnt;
    logic [BLK_W-1:0]  blk_cnt;
    logic              mv_en;
    logic [1:0]        mv_dir;

    // One STEP along an axis; signed 11-bit so a left/up move below zero is seen as negative.
    function automatic logic [9:0] step_coord(input logic [9:0] pos, input logic neg,
                                              input logic signed [10:0] lim);
        logic signed [10:0] cur;
        logic signed [10:0] nxt;
        cur = signed'({1'b0, pos});
        nxt = neg ? (cur - STEP_S) : (cur + STEP_S);
`ifdef SCREEN_WRAP_EN
        if (nxt[10])         nxt = lim;
        else if (nxt > lim)  nxt = '0;
`else
        if (nxt[10])         nxt = '0;
        else if (nxt > lim)  nxt = lim;
`endif
        return nxt[9:0];
    endfunction

    always_comb begin
        mv_en  = 1'b1;
        mv_dir = DIR_DOWN;
        case (lm.keycode)
            KEY_UP:    mv_dir = DIR_UP;
            KEY_DOWN:  mv_dir = DIR_DOWN;
            KEY_LEFT:  mv_dir = DIR_LEFT;
            KEY_RIGHT: mv_dir = DIR_RIGHT;
            default:   mv_en  = 1'b0;
        endcase
    end

    // Rising edge of the registered compare: one tick per frame however long the compare holds.
    assign tick_vld = tick_cmp_p0 & ~tick_cmp_p1;
    assign hit      = hit_q | lm.collision;

    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            tick_cmp_p0 <= 1'b0;
            tick_cmp_p1 <= 1'b0;
            hit_q       <= 1'b0;
            state       <= S_IDLE;
            pos_x       <= INIT_X_V;
            pos_y       <= INIT_Y_V;
            safe_x      <= INIT_X_V;
            safe_y      <= INIT_Y_V;
            facing_q    <= DIR_DOWN;
            anim_q      <= 1'b0;
            anim_cnt    <= '0;
            blk_cnt     <= '0;
            fu_q        <= 1'b0;
            blk_q       <= 1'b0;
        end else begin
            tick_cmp_p0 <= (lm.DrawY == TICK_LINE) && (lm.DrawX == 10'd0);
            tick_cmp_p1 <= tick_cmp_p0;
            hit_q       <= tick_vld ? 1'b0 : (hit_q | lm.collision);
            fu_q        <= tick_vld;
            if (tick_vld) begin
                case (state)
                    S_BLOCKED: begin
                        if (blk_cnt == '0) begin
                            state <= S_IDLE;
                            blk_q <= 1'b0;
                        end else begin
                            blk_cnt <= blk_cnt - BLK_W'(1);
                        end
                    end
                    default: begin
                        if (hit) begin
                            pos_x    <= safe_x;
                            pos_y    <= safe_y;
                            state    <= S_BLOCKED;
                            blk_q    <= 1'b1;
                            blk_cnt  <= BLK_LOAD;
                            anim_q   <= 1'b0;
                            anim_cnt <= '0;
                        end else if (mv_en) begin
                            safe_x   <= pos_x;
                            safe_y   <= pos_y;
                            facing_q <= mv_dir;
                            state    <= S_WALK;
                            case (mv_dir)
                                DIR_UP:   pos_y <= step_coord(pos_y, 1'b1, Y_MAX);
                                DIR_DOWN: pos_y <= step_coord(pos_y, 1'b0, Y_MAX);
                                DIR_LEFT: pos_x <= step_coord(pos_x, 1'b1, X_MAX);
                                default:  pos_x <= step_coord(pos_x, 1'b0, X_MAX);
                            endcase
                            if (anim_cnt == ANIM_LAST) begin
                                anim_cnt <= '0;
                                anim_q   <= ~anim_q;
                            end else begin
                                anim_cnt <= anim_cnt + ANIM_W'(1);
                            end
                        end else begin
                            safe_x   <= pos_x;
                            safe_y   <= pos_y;
                            state    <= S_IDLE;
                            anim_q   <= 1'b0;
                            anim_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign lm.spriteX      = pos_x;
    assign lm.spriteY      = pos_y;
    assign lm.sprite_size  = SIZE_V;
    assign lm.facing       = facing_q;
    assign lm.anim_frame   = anim_q;
    assign lm.frame_update = fu_q;
    assign lm.blocked      = blk_q;
endmodule
